bit_serial_subtractor: RTL and testbench
========================================

Name: bit_serial_subtractor

Overview:
- Sequential counterpart to the combinational full adder: a bit-serial subtractor computing a - b - borrow_in.
- One full-subtractor slice plus a registered borrow processes one bit per clock, LSB first.
- Captures two WIDTH-bit operands on a start handshake.
- Streams difference bits out serially, then presents the parallel difference and final borrow with a one-cycle done pulse.
- Used where area matters more than latency, and as the sequential exercise following the adder/subtractor cells.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  minuend; captured on the accepted start edge.
- b  input  WIDTH  subtrahend; captured on the accepted start edge.
- borrow_in  input  1  initial borrow; captured on the accepted start edge.
- busy  output  1  high in SHIFT and DONE states.
- done  output  1  one-cycle pulse when the result is ready.
- diff  output  WIDTH  parallel result; held until the next result.
- borrow_out  output  1  final borrow; 1 when a < b + borrow_in (unsigned).
- diff_bit  output  1  serial difference bit, LSB first.
- diff_bit_valid  output  1  qualifies diff_bit.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE. busy, done, diff, borrow_out, diff_bit, diff_bit_valid = 0. Internal shift registers, borrow register and bit counter are cleared.
- States: IDLE, SHIFT, DONE. All outputs are registered or decoded from registered state; there is no combinational path from inputs to outputs.
- IDLE:
  - On an edge with start=1: load a_sh=a, b_sh=b, br=borrow_in, cnt=0; go to SHIFT.
  - start=0: remain in IDLE.
- SHIFT: each edge processes bit a_sh[0], b_sh[0]:
  - d = a0 ^ b0 ^ br.
  - br_next = (~a0 & b0) | (~(a0 ^ b0) & br).
  - Shift a_sh and b_sh right by one.
  - Insert d at the MSB of the internal result shift register.
  - Register diff_bit=d and diff_bit_valid=1.
  - cnt increments.
  - At the edge processing bit WIDTH-1: go to DONE; load diff from the completed result register and borrow_out from br_next.
- DONE: done=1 and busy=1 for exactly one cycle. diff_bit_valid=1 still holds the MSB during this cycle. The next edge returns to IDLE and clears diff_bit_valid.
- Latency: start is sampled at edge E0. Bit k is presented after edge E0+k+1. done, diff and borrow_out are valid after edge E0+WIDTH. Back-to-back operation cost is WIDTH+2 cycles per operation.
- diff and borrow_out change only on entry to DONE, and hold through IDLE and the next operation until its DONE.
- start is ignored in SHIFT and DONE (no queuing). start held high continuously restarts on the first IDLE edge.
- a, b and borrow_in may change freely after the capture edge without affecting the operation.
- Wrap-around: results are modulo 2^WIDTH. Underflow is reported only through borrow_out.
- Reset mid-operation: the operation is aborted immediately, all outputs go to 0, and there is no done pulse. The next start after rst_n release behaves normally.

Test Plan:
- WIDTH=8, a=0x5A, b=0x3C, borrow_in=0 -> done after 8 edges; diff=0x1E, borrow_out=0. Serial stream LSB-first: 0,1,1,1,1,0,0,0.
- a=0x00, b=0x01, borrow_in=0 -> diff=0xFF, borrow_out=1. Then a=0x80, b=0x7F, borrow_in=1 -> diff=0x00, borrow_out=0.
- a=0xFF, b=0xFF, borrow_in=1 -> diff=0xFF, borrow_out=1. Previous diff stays held until this done.
- Pulse start again 3 cycles into an operation with different operands -> ignored: the single done carries only the first result, busy stays continuous, and a new start after IDLE is accepted.
- Drop rst_n 4 cycles into an operation -> outputs clear asynchronously, no done pulse. Release, start with a=0x10, b=0x01 -> diff=0x0F.
- 500 random a, b, borrow_in with random inter-start gaps -> each diff == (a-b-borrow_in) mod 256, borrow_out == (a < b+borrow_in), exactly 8 diff_bit_valid cycles per operation, done width 1.

Source files
------------

// File: rtl/bit_serial_subtractor.sv
// Bit-serial subtractor: a - b - borrow_in, one bit per clock, LSB first.
// Serial bits stream out while shifting; parallel result lands with done.
module bit_serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             diff_bit,
  output logic             diff_bit_valid
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             br_q, br_d;
  logic             bo_q, bo_d;
  logic             dbit_q, dbit_d;
  logic             dval_q, dval_d;

  logic a0, b0, d_bit, br_nx;

  // Full-subtractor slice on the current LSBs
  assign a0    = a_sh_q[0];
  assign b0    = b_sh_q[0];
  assign d_bit = a0 ^ b0 ^ br_q;
  assign br_nx = (~a0 & b0) | (~(a0 ^ b0) & br_q);

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    diff_d  = diff_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    bo_d    = bo_q;
    dbit_d  = dbit_q;
    dval_d  = dval_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          br_d    = borrow_in;
          cnt_d   = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        res_d  = {d_bit, res_q[WIDTH-1:1]};
        br_d   = br_nx;
        dbit_d = d_bit;
        dval_d = 1'b1;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          diff_d  = {d_bit, res_q[WIDTH-1:1]};
          bo_d    = br_nx;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        dval_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      bo_q    <= 1'b0;
      dbit_q  <= 1'b0;
      dval_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      diff_q  <= diff_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      bo_q    <= bo_d;
      dbit_q  <= dbit_d;
      dval_q  <= dval_d;
    end
  end

  assign busy           = (state_q != S_IDLE);
  assign done           = (state_q == S_DONE);
  assign diff           = diff_q;
  assign borrow_out     = bo_q;
  assign diff_bit       = dbit_q;
  assign diff_bit_valid = dval_q;

endmodule

// File: tb/tb_bit_serial_subtractor.sv
// Directed and random self-checking bench for bit_serial_subtractor.
// Inputs are driven and outputs sampled 1ns after each rising edge.
module tb_bit_serial_subtractor;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         borrow_in;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow_out;
  logic         diff_bit;
  logic         diff_bit_valid;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] last_diff = '0;

  bit_serial_subtractor #(.WIDTH(W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .a             (a),
    .b             (b),
    .borrow_in     (borrow_in),
    .busy          (busy),
    .done          (done),
    .diff          (diff),
    .borrow_out    (borrow_out),
    .diff_bit      (diff_bit),
    .diff_bit_valid(diff_bit_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    borrow_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, diff, borrow_out, diff_bit, diff_bit_valid} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b done=%b diff=%h bo=%b db=%b dv=%b expected all 0",
               busy, done, diff, borrow_out, diff_bit, diff_bit_valid);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got busy=%b expected 0", busy);
    end
  endtask

  // Entered while idle, 1ns after an edge; leaves in the same position.
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic bin, input logic [W-1:0] ed,
                        input logic eb, input string nm);
    a = av;
    b = bv;
    borrow_in = bin;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = ~av;
    b = W'($urandom);
    borrow_in = ~bin;
    for (int k = 0; k < W; k++) begin
      @(posedge clk);
      #1;
      checks++;
      if (diff_bit_valid !== 1'b1 || diff_bit !== ed[k]) begin
        errors++;
        $display("FAIL %s_bit%0d: got dv=%b db=%b expected dv=1 db=%b",
                 nm, k, diff_bit_valid, diff_bit, ed[k]);
      end
      checks++;
      if (done !== (k == W - 1) || busy !== 1'b1) begin
        errors++;
        $display("FAIL %s_ctl%0d: got done=%b busy=%b expected done=%b busy=1",
                 nm, k, done, busy, (k == W - 1));
      end
      if (k < W - 1) begin
        checks++;
        if (diff !== last_diff) begin
          errors++;
          $display("FAIL %s_hold%0d: got diff=%h expected %h", nm, k, diff, last_diff);
        end
      end
    end
    checks++;
    if (diff !== ed || borrow_out !== eb) begin
      errors++;
      $display("FAIL %s_result: got diff=%h bo=%b expected diff=%h bo=%b",
               nm, diff, borrow_out, ed, eb);
    end
    last_diff = ed;
    @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0 || diff_bit_valid !== 1'b0 || busy !== 1'b0 || diff !== ed) begin
      errors++;
      $display("FAIL %s_idle: got done=%b dv=%b busy=%b diff=%h expected 0 0 0 %h",
               nm, done, diff_bit_valid, busy, diff, ed);
    end
  endtask

  task automatic test_basic();
    run_op(8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, "basic");
  endtask

  task automatic test_wrap();
    run_op(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, "underflow");
    run_op(8'h80, 8'h7F, 1'b1, 8'h00, 1'b0, "zero");
    run_op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, "allones");
  endtask

  task automatic test_ignored_start();
    int dcnt;
    dcnt = 0;
    a = 8'h5A;
    b = 8'h3C;
    borrow_in = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int c = 1; c <= W + 1; c++) begin
      @(posedge clk);
      #1;
      if (c == 3) begin
        start = 1'b1;
        a = 8'h11;
        b = 8'h22;
        borrow_in = 1'b1;
      end
      if (c == 4) start = 1'b0;
      if (done === 1'b1) dcnt++;
      checks++;
      if (busy !== (c <= W)) begin
        errors++;
        $display("FAIL ign_busy%0d: got %b expected %b", c, busy, (c <= W));
      end
    end
    checks++;
    if (dcnt != 1 || diff !== 8'h1E || borrow_out !== 1'b0) begin
      errors++;
      $display("FAIL ign_result: got dones=%0d diff=%h bo=%b expected 1 1e 0",
               dcnt, diff, borrow_out);
    end
    last_diff = 8'h1E;
    run_op(8'h11, 8'h22, 1'b0, 8'hEF, 1'b1, "after_ign");
  endtask

  task automatic test_reset_mid();
    a = 8'hC3;
    b = 8'h21;
    borrow_in = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, diff, borrow_out, diff_bit, diff_bit_valid} !== '0) begin
      errors++;
      $display("FAIL midrst_clear: got busy=%b done=%b diff=%h bo=%b db=%b dv=%b expected all 0",
               busy, done, diff, borrow_out, diff_bit, diff_bit_valid);
    end
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL midrst_hold%0d: got done=%b busy=%b expected 0 0", c, done, busy);
      end
    end
    rst_n = 1'b1;
    last_diff = '0;
    @(posedge clk);
    #1;
    run_op(8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, "post_rst");
  endtask

  task automatic test_random();
    logic [W-1:0] ra, rb, ed, sb;
    logic         rbin, eb;
    int           vcnt, dcnt;
    logic [W-1:0] gd;
    logic         gb;
    for (int n = 0; n < 500; n++) begin
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
      ra   = W'($urandom);
      rb   = W'($urandom);
      rbin = 1'($urandom);
      {eb, ed} = {1'b0, ra} - {1'b0, rb} - {{W{1'b0}}, rbin};
      a = ra;
      b = rb;
      borrow_in = rbin;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      a = W'($urandom);
      b = W'($urandom);
      borrow_in = 1'($urandom);
      vcnt = 0;
      dcnt = 0;
      sb = '0;
      gd = '0;
      gb = 1'b0;
      for (int c = 0; c < W + 1; c++) begin
        @(posedge clk);
        #1;
        if (diff_bit_valid === 1'b1) begin
          if (vcnt < W) sb[vcnt] = diff_bit;
          vcnt++;
        end
        if (done === 1'b1) begin
          dcnt++;
          gd = diff;
          gb = borrow_out;
        end
      end
      checks++;
      if (gd !== ed || gb !== eb || sb !== ed) begin
        errors++;
        $display("FAIL rand%0d_value: a=%h b=%h bin=%b got diff=%h bo=%b stream=%h expected %h %b",
                 n, ra, rb, rbin, gd, gb, sb, ed, eb);
      end
      checks++;
      if (vcnt != W || dcnt != 1 || busy !== 1'b0) begin
        errors++;
        $display("FAIL rand%0d_timing: got valids=%0d dones=%0d busy=%b expected %0d 1 0",
                 n, vcnt, dcnt, busy, W);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_ignored_start();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
